// File: rtl/func_eval.sv
// func_eval: three-stage valid/ready pipeline computing w = (z*z >>> SCALE_SHIFT) + c.
// Optional macro FUNC_EVAL_SAT_EN clamps results and counts saturated beats per frame.

module func_eval #(
    parameter int SCALE_SHIFT = 7,
    parameter int CW          = 10
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic signed [9:0]    z_re,
    input  logic signed [8:0]    z_im,
    input  logic                 in_first,
    input  logic                 in_lastx,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [CW-1:0] c_re,
    input  logic signed [CW-1:0] c_im,
    output logic signed [9:0]    w_re,
    output logic signed [8:0]    w_im,
    output logic                 out_first,
    output logic                 out_lastx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          sat_count
);
    localparam int PW = 21;
    localparam int SW = ((PW > CW) ? PW : CW) + 2;

    logic                 ready_en_q, ready_en_d;
    logic signed [CW-1:0] c_re_q, c_re_d, c_im_q, c_im_d;

    logic                 s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_lastx_q, s1_lastx_d;
    logic signed [PW-1:0] s1_rr_q, s1_rr_d, s1_ii_q, s1_ii_d, s1_ri_q, s1_ri_d;
    logic signed [CW-1:0] s1_cre_q, s1_cre_d, s1_cim_q, s1_cim_d;

    logic                 s2_v_q, s2_v_d, s2_first_q, s2_first_d, s2_lastx_q, s2_lastx_d;
    logic signed [SW-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;

    logic                 s3_v_q, s3_v_d, s3_first_q, s3_first_d, s3_lastx_q, s3_lastx_d;
    logic signed [9:0]    s3_re_q, s3_re_d;
    logic signed [8:0]    s3_im_q, s3_im_d;
    logic                 sat_q, sat_d;
    logic [15:0]          sat_acc_q, sat_acc_d, sat_count_q, sat_count_d;

    logic                 en1, en2, en3, accept;
    logic signed [SW-1:0] rr_x, ii_x, ri_x, re_full, im_full;
    logic signed [9:0]    re_fin;
    logic signed [8:0]    im_fin;
    logic                 sat_fin;

    // Final-stage range handling: clamp with a flag, or plain two's-complement wrap.
`ifdef FUNC_EVAL_SAT_EN
    localparam logic signed [SW-1:0] RE_MAX = SW'(511);
    localparam logic signed [SW-1:0] RE_MIN = SW'(-512);
    localparam logic signed [SW-1:0] IM_MAX = SW'(255);
    localparam logic signed [SW-1:0] IM_MIN = SW'(-256);

    always_comb begin
        re_fin  = s2_re_q[9:0];
        im_fin  = s2_im_q[8:0];
        sat_fin = 1'b0;
        if (s2_re_q > RE_MAX) begin
            re_fin  = 10'sd511;
            sat_fin = 1'b1;
        end else if (s2_re_q < RE_MIN) begin
            re_fin  = -10'sd512;
            sat_fin = 1'b1;
        end
        if (s2_im_q > IM_MAX) begin
            im_fin  = 9'sd255;
            sat_fin = 1'b1;
        end else if (s2_im_q < IM_MIN) begin
            im_fin  = -9'sd256;
            sat_fin = 1'b1;
        end
    end
`else
    logic unused_hi;
    assign re_fin    = s2_re_q[9:0];
    assign im_fin    = s2_im_q[8:0];
    assign sat_fin   = 1'b0;
    assign unused_hi = ^{s2_re_q[SW-1:10], s2_im_q[SW-1:9]};
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        ready_en_d  = 1'b1;
        c_re_d      = c_re_q;      c_im_d      = c_im_q;
        s1_v_d      = s1_v_q;      s1_first_d  = s1_first_q;  s1_lastx_d  = s1_lastx_q;
        s1_rr_d     = s1_rr_q;     s1_ii_d     = s1_ii_q;     s1_ri_d     = s1_ri_q;
        s1_cre_d    = s1_cre_q;    s1_cim_d    = s1_cim_q;
        s2_v_d      = s2_v_q;      s2_first_d  = s2_first_q;  s2_lastx_d  = s2_lastx_q;
        s2_re_d     = s2_re_q;     s2_im_d     = s2_im_q;
        s3_v_d      = s3_v_q;      s3_first_d  = s3_first_q;  s3_lastx_d  = s3_lastx_q;
        s3_re_d     = s3_re_q;     s3_im_d     = s3_im_q;     sat_d       = sat_q;
        sat_acc_d   = sat_acc_q;   sat_count_d = sat_count_q;

        en3      = !s3_v_q || out_ready;
        en2      = !s2_v_q || en3;
        en1      = !s1_v_q || en2;
        in_ready = ready_en_q && en1;
        accept   = in_valid && in_ready;

        // The beat carries its own c so older in-flight beats keep the previous constant.
        if (accept && in_first) begin
            c_re_d = c_re;
            c_im_d = c_im;
        end
        if (en1) s1_v_d = accept;
        if (accept) begin
            s1_rr_d    = PW'(z_re) * PW'(z_re);
            s1_ii_d    = PW'(z_im) * PW'(z_im);
            s1_ri_d    = PW'(z_re) * PW'(z_im);
            s1_cre_d   = in_first ? c_re : c_re_q;
            s1_cim_d   = in_first ? c_im : c_im_q;
            s1_first_d = in_first;
            s1_lastx_d = in_lastx;
        end

        rr_x    = SW'(s1_rr_q);
        ii_x    = SW'(s1_ii_q);
        ri_x    = SW'(s1_ri_q);
        re_full = ((rr_x - ii_x) >>> SCALE_SHIFT) + SW'(s1_cre_q);
        im_full = ((ri_x <<< 1) >>> SCALE_SHIFT) + SW'(s1_cim_q);
        if (en2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_re_d    = re_full;
                s2_im_d    = im_full;
                s2_first_d = s1_first_q;
                s2_lastx_d = s1_lastx_q;
            end
        end

        if (en3) begin
            s3_v_d = s2_v_q;
            if (s2_v_q) begin
                s3_re_d    = re_fin;
                s3_im_d    = im_fin;
                sat_d      = sat_fin;
                s3_first_d = s2_first_q;
                s3_lastx_d = s2_lastx_q;
            end
        end

        if (s3_v_q && out_ready) begin
            if (s3_first_q) begin
                sat_count_d = sat_acc_q;
                sat_acc_d   = {15'd0, sat_q};
            end else if (sat_q && (sat_acc_q != 16'hFFFF)) begin
                sat_acc_d = sat_acc_q + 16'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_en_q <= 1'b0;
            c_re_q     <= '0;  c_im_q     <= '0;
            s1_v_q     <= 1'b0; s1_first_q <= 1'b0; s1_lastx_q <= 1'b0;
            s1_rr_q    <= '0;  s1_ii_q    <= '0;  s1_ri_q    <= '0;
            s1_cre_q   <= '0;  s1_cim_q   <= '0;
            s2_v_q     <= 1'b0; s2_first_q <= 1'b0; s2_lastx_q <= 1'b0;
            s2_re_q    <= '0;  s2_im_q    <= '0;
            s3_v_q     <= 1'b0; s3_first_q <= 1'b0; s3_lastx_q <= 1'b0;
            s3_re_q    <= '0;  s3_im_q    <= '0;  sat_q      <= 1'b0;
            sat_acc_q  <= '0;  sat_count_q <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            c_re_q     <= c_re_d;    c_im_q     <= c_im_d;
            s1_v_q     <= s1_v_d;    s1_first_q <= s1_first_d; s1_lastx_q <= s1_lastx_d;
            s1_rr_q    <= s1_rr_d;   s1_ii_q    <= s1_ii_d;    s1_ri_q    <= s1_ri_d;
            s1_cre_q   <= s1_cre_d;  s1_cim_q   <= s1_cim_d;
            s2_v_q     <= s2_v_d;    s2_first_q <= s2_first_d; s2_lastx_q <= s2_lastx_d;
            s2_re_q    <= s2_re_d;   s2_im_q    <= s2_im_d;
            s3_v_q     <= s3_v_d;    s3_first_q <= s3_first_d; s3_lastx_q <= s3_lastx_d;
            s3_re_q    <= s3_re_d;   s3_im_q    <= s3_im_d;    sat_q      <= sat_d;
            sat_acc_q  <= sat_acc_d; sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s3_v_q;
    assign out_first = s3_first_q;
    assign out_lastx = s3_lastx_q;
    assign w_re      = s3_re_q;
    assign w_im      = s3_im_q;
    assign sat_count = sat_count_q;

endmodule

// File: doc/func_eval.md
FUNC_EVAL -- requirements
Module: func_eval

Interface
REQ-001 Parameter SCALE_SHIFT, default 7: arithmetic right shift applied to z^2 products before adding c.
REQ-002 Parameter CW, default 10: width of signed constants c_re and c_im.
REQ-003 Port aclk, input, 1: single clock; all logic is rising-edge.
REQ-004 Port areset, input, 1: asynchronous, active-high reset.
REQ-005 Port z_re / z_im, input, 10 / 9, signed: coordinate from coord_gen.
REQ-006 Port in_first / in_lastx, input, 1 / 1: start-of-frame / end-of-line sideband.
REQ-007 Port in_valid / in_ready, input / output, 1 / 1: upstream handshake.
REQ-008 Port c_re / c_im, input, CW / CW, signed: additive constant from the register file; quasi-static.
REQ-009 Port w_re / w_im, output, 10 / 9, signed: result to atan_lut.
REQ-010 Port out_first / out_lastx, output, 1 / 1: sideband delayed in step with the data.
REQ-011 Port out_valid / out_ready, output / input, 1 / 1: downstream handshake.
REQ-012 Port sat_count, output, 16: number of saturated beats in the previous complete frame.

Function
REQ-013 Computes w = (z*z >>> SCALE_SHIFT) + c, with re = z_re^2 - z_im^2 and im = 2*z_re*z_im, at full precision of at least 21 bits until the final stage.
REQ-014 Three-stage pipeline: S1 registers products; S2 does subtract/shift/add c; S3 does saturate and output register.
REQ-015 Latency: 3 cycles from input accept to out_valid when out_ready=1.
REQ-016 Throughput: one beat per cycle with no bubbles when out_ready stays high.
REQ-017 Stage k loads when stage k is empty or stage k+1 loads in the same cycle; S3 empties on out_valid&&out_ready.
REQ-018 in_ready = !S1_valid || S1 advances; beats are never dropped or duplicated under backpressure.
REQ-019 out_valid and all out_* data are register outputs and stay stable while out_valid&&!out_ready.
REQ-020 in_first and in_lastx travel with their beat unchanged.
REQ-021 c_re/c_im are sampled into internal c registers only on an accepted beat with in_first=1; that beat and all later beats use the new value.
REQ-022 sat_acc (16-bit) increments on each saturated beat leaving S3, and saturates at 0xFFFF rather than wrapping.
REQ-023 On an accepted out_first beat, sat_count <= sat_acc and sat_acc is set to that beat's saturation flag (0 or 1).
REQ-024 Simultaneous in and out handshakes in the same cycle are both honoured.

Reset
REQ-025 On areset, all stage valids, out_valid, out_first, out_lastx, w_re, w_im, sat_acc, sat_count and the internal c registers go to 0 immediately, without waiting for a clock.
REQ-026 While areset is high, in_ready = 0; it returns to 1 on the first clock after release.
REQ-027 Any in-flight beats are discarded on reset mid-frame; there is no partial output.

Configuration
REQ-028 Macro FUNC_EVAL_SAT_EN defined: results outside the range are clamped to 10-bit [-512,511] and 9-bit [-256,255], and each clamp sets the saturation flag.
REQ-029 Macro FUNC_EVAL_SAT_EN undefined: results are truncated to their low bits (two's-complement wrap), the saturation flag is 0, and sat_count is 0.

Verification
REQ-030 c=(0,0), z=(100,50), out_ready=1 -> w=(58,78) exactly 3 cycles after accept.
REQ-031 SAT_EN, c=0, z=(-512,0) -> w_re=511, w_im=0; next frame's first beat sets sat_count=1. Without SAT_EN -> w_re=0, sat_count=0.
REQ-032 Stream 8 beats with out_ready low for cycles 2-6 -> in_ready falls once 3 are in flight, all 8 emerge in order, held data is stable.
REQ-033 c_re changed 0->20 mid-frame -> unchanged output until next in_first beat; z=(0,0) then yields w=(20,0).
REQ-034 areset pulsed with 3 beats in flight -> out_valid=0 asynchronously, no stale beat after release, sat_count=0.
